// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg
//   Shared definitions for the fetch sequencer: data widths, instruction
//   field positions, opcode and register encodings, FSM state encoding and
//   small field-extraction helpers.
package fetch_sequencer_pkg;

   localparam int unsigned PC_W    = 16;
   localparam int unsigned INSTR_W = 28;
   localparam int unsigned IMM_W   = 24;
   localparam int unsigned OPC_W   = 4;

   // Instruction field positions: opcode [27:24], immediate [23:0]
   localparam int unsigned OPC_MSB = 27;
   localparam int unsigned OPC_LSB = 24;
   localparam int unsigned IMM_MSB = 23;
   localparam int unsigned IMM_LSB = 0;

   typedef enum logic [OPC_W-1:0] {
      OP_NOP = 4'h0,
      OP_ADD = 4'h1,
      OP_SUB = 4'h2,
      OP_AND = 4'h3,
      OP_OR  = 4'h4,
      OP_LD  = 4'h5,
      OP_ST  = 4'h6,
      OP_BR  = 4'h7
   } opcode_e;

   typedef enum logic [3:0] {
      REG_R0 = 4'h0,
      REG_R1 = 4'h1,
      REG_R2 = 4'h2,
      REG_R3 = 4'h3
   } reg_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DELAY = 2'd2
   } state_e;

   function automatic logic [OPC_W-1:0] get_opcode(input logic [INSTR_W-1:0] w);
      return w[OPC_MSB:OPC_LSB];
   endfunction

   function automatic logic [IMM_W-1:0] get_imm(input logic [INSTR_W-1:0] w);
      return w[IMM_MSB:IMM_LSB];
   endfunction

   // A NOP with a nonzero immediate requests a stall of that many cycles
   function automatic logic is_delay_nop(input logic [INSTR_W-1:0] w);
      return (get_opcode(w) == OP_NOP) && (get_imm(w) != 24'd0);
   endfunction

endpackage

// File: rtl/fetch_sequencer_delay_counter.sv
// delay_counter
//   24-bit loadable down-counter that tracks the remaining NOP stall cycles.
//   Ports:
//     clk_i, rst_i   : clock, asynchronous active-high reset
//     clr_i          : clear to zero (highest priority)
//     load_i         : load load_val_i
//     load_val_i     : value to load
//     en_i           : decrement by one (stops at zero)
//     count_o        : current count
//     zero_o         : count is zero
module delay_counter
   import fetch_sequencer_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             load_i,
   input  logic [IMM_W-1:0] load_val_i,
   input  logic             en_i,
   output logic [IMM_W-1:0] count_o,
   output logic             zero_o
);

   logic [IMM_W-1:0] count_q;
   logic [IMM_W-1:0] count_d;

   // Next count: clear beats load beats decrement
   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = 24'd0;
      end else if (load_i) begin
         count_d = load_val_i;
      end else if (en_i && (count_q != 24'd0)) begin
         count_d = count_q - 24'd1;
      end else begin
         count_d = count_q;
      end
   end

   // Count register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q <= 24'd0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
   assign zero_o  = (count_q == 24'd0);

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Instruction fetch stage: drives the ROM address from the PC, registers
//   the returned word towards execute, honours stall/branch requests and
//   turns NOPs with a nonzero immediate into multi-cycle stalls.
//   Ports:
//     Clock, Reset    : rising-edge clock, asynchronous active-high reset
//     iEnable         : run enable (low parks the sequencer in IDLE)
//     iStall          : execute hold request
//     iBranchTaken    : redirect request, iBranchTarget is the new PC
//     iInstruction    : ROM data for oAddress
//     oAddress        : ROM address (the PC register)
//     oInstruction    : issued instruction, oPC its address, oValid qualifier
//     oDelaying       : high for the cycles a NOP stall holds oValid low
module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter logic [15:0] RESET_PC = 16'd0,
   parameter int unsigned DELAY_EN = 1
)(
   input  logic               Clock,
   input  logic               Reset,
   input  logic               iEnable,
   input  logic               iStall,
   input  logic               iBranchTaken,
   input  logic [PC_W-1:0]    iBranchTarget,
   input  logic [INSTR_W-1:0] iInstruction,
   output logic [PC_W-1:0]    oAddress,
   output logic [INSTR_W-1:0] oInstruction,
   output logic [PC_W-1:0]    oPC,
   output logic               oValid,
   output logic               oDelaying
);

   state_e               state_q, state_d, eff_state_s;
   logic [PC_W-1:0]      pc_q, pc_d;
   logic [INSTR_W-1:0]   instr_q, instr_d;
   logic [PC_W-1:0]      opc_q, opc_d;
   logic                 valid_q, valid_d;
   logic                 delaying_q, delaying_d;

   logic                 cnt_clr_s, cnt_load_s, cnt_en_s, cnt_zero_s;
   logic [IMM_W-1:0]     cnt_count_s;

   delay_counter u_delay_counter (
      .clk_i      (Clock),
      .rst_i      (Reset),
      .clr_i      (cnt_clr_s),
      .load_i     (cnt_load_s),
      .load_val_i (get_imm(iInstruction)),
      .en_i       (cnt_en_s),
      .count_o    (cnt_count_s),
      .zero_o     (cnt_zero_s)
   );

   // Next-state and datapath decisions for the fetch FSM
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      instr_d     = instr_q;
      opc_d       = opc_q;
      valid_d     = valid_q;
      delaying_d  = 1'b0;
      cnt_clr_s   = 1'b0;
      cnt_load_s  = 1'b0;
      cnt_en_s    = 1'b0;

      // The state that acts this cycle: enabling IDLE acts immediately as
      // RUN, or as DELAY when a frozen count is still pending; disabling
      // RUN/DELAY parks with everything held.
      case (state_q)
         ST_IDLE: begin
            if (iEnable) begin
               if (cnt_zero_s) eff_state_s = ST_RUN;
               else            eff_state_s = ST_DELAY;
            end else begin
               eff_state_s = ST_IDLE;
            end
         end
         ST_RUN, ST_DELAY: begin
            if (iEnable) eff_state_s = state_q;
            else         eff_state_s = ST_IDLE;
         end
         default: eff_state_s = ST_IDLE;
      endcase

      case (eff_state_s)
         ST_IDLE: begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
         end
         ST_RUN: begin
            if (iBranchTaken) begin
               // The word fetched this cycle is dropped
               pc_d    = iBranchTarget;
               valid_d = 1'b0;
               state_d = ST_RUN;
            end else if (iStall) begin
               state_d = ST_RUN;
            end else begin
               instr_d = iInstruction;
               opc_d   = pc_q;
               valid_d = 1'b1;
               pc_d    = pc_q + 16'd1;
               if ((DELAY_EN != 32'd0) && is_delay_nop(iInstruction)) begin
                  cnt_load_s = 1'b1;
                  state_d    = ST_DELAY;
               end else begin
                  state_d    = ST_RUN;
               end
            end
         end
         ST_DELAY: begin
            if (iBranchTaken) begin
               cnt_clr_s = 1'b1;
               pc_d      = iBranchTarget;
               valid_d   = 1'b0;
               state_d   = ST_RUN;
            end else begin
               // Stall is ignored here; the count keeps running
               valid_d    = 1'b0;
               delaying_d = 1'b1;
               cnt_en_s   = 1'b1;
               if (cnt_count_s <= 24'd1) state_d = ST_RUN;
               else                      state_d = ST_DELAY;
            end
         end
         default: begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q    <= ST_IDLE;
         pc_q       <= RESET_PC;
         instr_q    <= 28'd0;
         opc_q      <= 16'd0;
         valid_q    <= 1'b0;
         delaying_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         opc_q      <= opc_d;
         valid_q    <= valid_d;
         delaying_q <= delaying_d;
      end
   end

   assign oAddress     = pc_q;
   assign oInstruction = instr_q;
   assign oPC          = opc_q;
   assign oValid       = valid_q;
   assign oDelaying    = delaying_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer
//   Directed scenarios followed by a randomized run. Two sequencers share
//   the control inputs: dut0 (RESET_PC 0, NOP delays on) and dut1
//   (RESET_PC FFFF, NOP delays off). Each reads its own view of a 256-word
//   ROM. A reference model tracks PC, remaining delay cycles and outputs.
module tb_fetch_sequencer;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        en, stall, br;
   logic [15:0] tgt;

   logic [27:0] rom [0:255];

   logic [15:0] a0, a1, op0, op1;
   logic [27:0] i0, i1, oi0, oi1;
   logic        v0, v1, d0, d1;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   // reference model state, index 0 = dut0, 1 = dut1
   logic [15:0] m_pc    [2];
   int          m_rem   [2];
   logic [27:0] m_instr [2];
   logic [15:0] m_opc   [2];
   logic        m_v     [2];
   logic        m_d     [2];

   assign i0 = rom[a0[7:0]];
   assign i1 = rom[a1[7:0]];

   always #5 Clock = ~Clock;

   fetch_sequencer #(.RESET_PC(16'h0000), .DELAY_EN(1)) dut0 (
      .Clock(Clock), .Reset(Reset), .iEnable(en), .iStall(stall),
      .iBranchTaken(br), .iBranchTarget(tgt), .iInstruction(i0),
      .oAddress(a0), .oInstruction(oi0), .oPC(op0), .oValid(v0), .oDelaying(d0));

   fetch_sequencer #(.RESET_PC(16'hFFFF), .DELAY_EN(0)) dut1 (
      .Clock(Clock), .Reset(Reset), .iEnable(en), .iStall(stall),
      .iBranchTaken(br), .iBranchTarget(tgt), .iInstruction(i1),
      .oAddress(a1), .oInstruction(oi1), .oPC(op1), .oValid(v1), .oDelaying(d1));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc[0] = 16'h0000;
      m_pc[1] = 16'hFFFF;
      for (int k = 0; k < 2; k++) begin
         m_rem[k] = 0; m_instr[k] = 28'd0; m_opc[k] = 16'd0;
         m_v[k] = 1'b0; m_d[k] = 1'b0;
      end
   endtask

   // One clock edge of the behaviour: disabled -> park; branch -> redirect
   // with a bubble; pending delay -> burn one cycle; stall -> hold; else issue.
   task automatic model_step();
      logic [27:0] w;
      for (int k = 0; k < 2; k++) begin
         w = rom[m_pc[k][7:0]];
         if (!en) begin
            m_v[k] = 1'b0; m_d[k] = 1'b0;
         end else if (br) begin
            m_pc[k] = tgt; m_rem[k] = 0; m_v[k] = 1'b0; m_d[k] = 1'b0;
         end else if (m_rem[k] > 0) begin
            m_rem[k] = m_rem[k] - 1; m_v[k] = 1'b0; m_d[k] = 1'b1;
         end else if (stall) begin
            m_d[k] = 1'b0;
         end else begin
            m_instr[k] = w; m_opc[k] = m_pc[k]; m_v[k] = 1'b1; m_d[k] = 1'b0;
            m_pc[k] = m_pc[k] + 16'd1;
            if (k == 0 && w[27:24] == 4'h0 && w[23:0] != 24'd0) m_rem[k] = int'(w[23:0]);
         end
      end
   endtask

   task automatic compare_all();
      chk("dut0 oAddress",     {16'd0, a0},  {16'd0, m_pc[0]});
      chk("dut0 oInstruction", {4'd0, oi0},  {4'd0, m_instr[0]});
      chk("dut0 oPC",          {16'd0, op0}, {16'd0, m_opc[0]});
      chk("dut0 oValid",       {31'd0, v0},  {31'd0, m_v[0]});
      chk("dut0 oDelaying",    {31'd0, d0},  {31'd0, m_d[0]});
      chk("dut1 oAddress",     {16'd0, a1},  {16'd0, m_pc[1]});
      chk("dut1 oInstruction", {4'd0, oi1},  {4'd0, m_instr[1]});
      chk("dut1 oPC",          {16'd0, op1}, {16'd0, m_opc[1]});
      chk("dut1 oValid",       {31'd0, v1},  {31'd0, m_v[1]});
      chk("dut1 oDelaying",    {31'd0, d1},  {31'd0, m_d[1]});
   endtask

   task automatic cycle();
      @(posedge Clock);
      model_step();
      @(negedge Clock);
      compare_all();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1);
   end

   initial begin
      Reset = 1'b1; en = 1'b1; stall = 1'b0; br = 1'b0; tgt = 16'd0;
      for (int i = 0; i < 256; i++) rom[i] = {4'h1, 24'(i)};
      rom[12] = {4'h0, 24'd3};
      model_reset();
      repeat (2) @(negedge Clock);

      // reset values
      compare_all();
      chk("reset oValid",        {31'd0, v0},  32'd0);
      chk("reset oPC",           {16'd0, op0}, 32'd0);
      chk("reset oInstruction",  {4'd0, oi0},  32'd0);
      chk("reset oDelaying",     {31'd0, d0},  32'd0);
      chk("reset oAddress",      {16'd0, a0},  32'd0);
      chk("reset oAddress wrap", {16'd0, a1},  32'h0000FFFF);
      Reset = 1'b0;

      // sequential fetch, and wrap on dut1
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("seq oPC",      {16'd0, op0}, 32'(i));
         chk("seq oValid",   {31'd0, v0},  32'd1);
         chk("seq oAddress", {16'd0, a0},  32'(i + 1));
         chk("wrap oPC",     {16'd0, op1}, {16'd0, 16'(16'hFFFF + i)});
      end

      // branch to 8 while oPC is 9
      repeat (7) cycle();
      chk("pre-branch oPC", {16'd0, op0}, 32'd9);
      br = 1'b1; tgt = 16'd8;
      cycle();
      br = 1'b0;
      chk("branch bubble oValid", {31'd0, v0}, 32'd0);
      chk("branch oAddress",      {16'd0, a0}, 32'd8);
      cycle();
      chk("branch oPC target", {16'd0, op0}, 32'd8);
      chk("branch oValid",     {31'd0, v0},  32'd1);
      cycle();
      chk("branch oPC next",   {16'd0, op0}, 32'd9);

      // NOP with immediate 3 at address 12
      repeat (3) cycle();
      chk("nop oPC",          {16'd0, op0}, 32'd12);
      chk("nop oValid",       {31'd0, v0},  32'd1);
      chk("nop oInstruction", {4'd0, oi0},  {4'd0, 4'h0, 24'd3});
      cycle();
      chk("delay oValid",     {31'd0, v0},  32'd0);
      chk("delay oDelaying",  {31'd0, d0},  32'd1);
      chk("nodelay oPC",      {16'd0, op1}, 32'd13);
      chk("nodelay oDelaying",{31'd0, d1},  32'd0);
      for (int i = 0; i < 2; i++) begin
         cycle();
         chk("delay oValid",    {31'd0, v0}, 32'd0);
         chk("delay oDelaying", {31'd0, d0}, 32'd1);
         chk("delay oAddress",  {16'd0, a0}, 32'd13);
      end
      cycle();
      chk("post-delay oPC",       {16'd0, op0}, 32'd13);
      chk("post-delay oValid",    {31'd0, v0},  32'd1);
      chk("post-delay oDelaying", {31'd0, d0},  32'd0);

      // stall freezes outputs for 4 cycles
      stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("stall oPC",          {16'd0, op0}, 32'd13);
         chk("stall oValid",       {31'd0, v0},  32'd1);
         chk("stall oAddress",     {16'd0, a0},  32'd14);
         chk("stall oInstruction", {4'd0, oi0},  {4'd0, 4'h1, 24'd13});
      end
      // branch wins over stall
      br = 1'b1; tgt = 16'd5;
      cycle();
      chk("stall+branch oValid",   {31'd0, v0}, 32'd0);
      chk("stall+branch oAddress", {16'd0, a0}, 32'd5);
      br = 1'b0; stall = 1'b0;
      cycle();
      chk("stall+branch oPC", {16'd0, op0}, 32'd5);

      // randomized run
      for (int i = 0; i < 256; i++) begin
         if ($urandom_range(0, 9) < 3) rom[i] = {4'h0, 24'($urandom_range(0, 5))};
         else                          rom[i] = {4'($urandom_range(1, 7)), 24'($urandom)};
      end
      for (int n = 0; n < 400; n++) begin
         en    = ($urandom_range(0, 9) != 0);
         stall = ($urandom_range(0, 4) == 0);
         br    = ($urandom_range(0, 9) == 0);
         tgt   = 16'($urandom_range(0, 255));
         cycle();
      end

      // reset two cycles into a NOP 4000 delay
      en = 1'b1; stall = 1'b0;
      rom[20] = {4'h0, 24'd4000};
      br = 1'b1; tgt = 16'd20;
      cycle();
      br = 1'b0;
      cycle();
      chk("long nop oPC", {16'd0, op0}, 32'd20);
      repeat (2) cycle();
      chk("long nop oDelaying", {31'd0, d0}, 32'd1);
      #2 Reset = 1'b1;
      #1;
      chk("async reset oValid",       {31'd0, v0},  32'd0);
      chk("async reset oDelaying",    {31'd0, d0},  32'd0);
      chk("async reset oPC",          {16'd0, op0}, 32'd0);
      chk("async reset oInstruction", {4'd0, oi0},  32'd0);
      chk("async reset oAddress",     {16'd0, a0},  32'd0);
      chk("async reset oAddress wrap",{16'd0, a1},  32'h0000FFFF);
      model_reset();
      @(negedge Clock);
      Reset = 1'b0;
      cycle();
      chk("restart oPC",          {16'd0, op0}, 32'd0);
      chk("restart oValid",       {31'd0, v0},  32'd1);
      chk("restart oInstruction", {4'd0, oi0},  {4'd0, rom[0]});
      chk("restart oAddress",     {16'd0, a0},  32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'd0, the program counter value loaded on reset.
REQ-002 SHALL have parameter DELAY_EN, default 1; when 1, a NOP immediate acts as a stall count, and when 0, a NOP is issued without delay.
REQ-003 SHALL have port Clock, input, 1 bit: the single rising-edge clock.
REQ-004 SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port iEnable, input, 1 bit: run enable.
REQ-006 SHALL have port iStall, input, 1 bit: execute-stage hold request.
REQ-007 SHALL have port iBranchTaken, input, 1 bit: redirect request from execute.
REQ-008 SHALL have port iBranchTarget, input, 16 bits: redirect address.
REQ-009 SHALL have port iInstruction, input, 28 bits: combinational instruction-ROM data for oAddress.
REQ-010 SHALL have port oAddress, output, 16 bits: instruction-ROM address, equal to the PC register.
REQ-011 SHALL have port oInstruction, output, 28 bits: registered instruction issued to execute.
REQ-012 SHALL have port oPC, output, 16 bits: address of the instruction on oInstruction.
REQ-013 SHALL have port oValid, output, 1 bit: oInstruction is valid this cycle.
REQ-014 SHALL have port oDelaying, output, 1 bit: high while in the DELAY state.

Function
REQ-015 SHALL implement a state machine with states IDLE, RUN and DELAY.
REQ-016 SHALL move from IDLE to RUN when iEnable=1; in IDLE, PC holds and oValid=0.
REQ-017 SHALL issue one instruction per cycle in RUN when iStall=0 and iBranchTaken=0: oInstruction<=iInstruction, oPC<=PC, oValid<=1, PC<=PC+1.
REQ-018 SHALL wrap PC from 16'hFFFF to 16'h0000 with no flag.
REQ-019 SHALL give iBranchTaken priority over iStall.
REQ-020 SHALL, on iBranchTaken, load PC<=iBranchTarget and set oValid<=0 for exactly one cycle; the instruction fetched in that cycle is discarded.
REQ-021 SHALL, on iStall=1 with no branch, hold PC, oInstruction, oPC and oValid unchanged.
REQ-022 SHALL, when DELAY_EN=1 and an issued instruction has opcode NOP with a nonzero 24-bit immediate N, issue the NOP normally (oValid=1), load the 24-bit counter with N, and enter DELAY on the next edge.
REQ-023 SHALL, in DELAY, hold oValid=0, hold PC, assert oDelaying=1, and decrement the counter each cycle; after exactly N DELAY cycles it SHALL return to RUN.
REQ-024 SHALL treat a NOP with immediate 0 as a plain single-cycle issue with no DELAY entry.
REQ-025 SHALL, on iBranchTaken during DELAY, abort the delay, clear the counter, apply REQ-020 and enter RUN.
REQ-026 SHALL ignore iStall during DELAY; the count continues.
REQ-027 SHALL, on iEnable=0 in RUN, complete the current cycle, enter IDLE with PC held and oValid<=0; on re-enable, it resumes from the held PC.
REQ-028 SHALL, on iEnable=0 in DELAY, freeze the counter and enter IDLE, then resume DELAY with the remaining count on re-enable.
REQ-029 SHALL have 1-cycle latency from oAddress to a valid oInstruction.

Reset
REQ-030 SHALL, while Reset=1 (asynchronous), force: state=IDLE, PC=RESET_PC, oInstruction=28'd0, oPC=16'd0, oValid=0, oDelaying=0, counter=0.
REQ-031 SHALL, on reset mid-DELAY or mid-branch, discard all pending work; the first fetch after release is from RESET_PC.

Structure
REQ-032 SHALL take opcode encodings (NOP and others), register encodings, instruction field positions (opcode [27:24], immediate [23:0]) and the state encodings from the shared definitions file.
REQ-033 SHALL contain one sub-module, delay_counter: a 24-bit loadable down-counter with load, enable and zero-flag.

Verification
REQ-034 SHALL verify reset and sequential fetch: release reset with iEnable=1 and ROM words 0..3 -> oAddress 0,1,2,3; oValid high from cycle 1; oPC 0,1,2 in order.
REQ-035 SHALL verify branch: iBranchTaken=1 with iBranchTarget=8 while oPC=9 -> one cycle oValid=0, then oPC=8, then 9.
REQ-036 SHALL verify NOP delay: NOP with immediate 3 at address 12 -> oPC=12 valid, then exactly 3 cycles of oValid=0 with oDelaying=1, then oPC=13.
REQ-037 SHALL verify stall versus branch: iStall=1 for 4 cycles -> outputs frozen; iStall=1 with iBranchTaken=1 and iBranchTarget=5 together -> redirect to 5.
REQ-038 SHALL verify wrap: RESET_PC=16'hFFFF -> oPC FFFF, then 0000.
REQ-039 SHALL verify reset mid-operation: Reset asserted 2 cycles into a NOP with immediate 4000 -> all outputs go to reset values immediately, and the fetch restarts at RESET_PC.
